// File: rtl/cache_request_arbiter_pkg.sv
// Shared memory-path types for the cache front-end: request/response packets,
// tag FIFO control structs and the packet-to-cache-request mapping.
package cache_request_arbiter_pkg;

    localparam int CACHE_FRONTEND_ADDR_W = 24;
    localparam int CACHE_CTRL_CNT        = 2;
    localparam int CACHE_ADDR_W          = CACHE_FRONTEND_ADDR_W + CACHE_CTRL_CNT;
    localparam int CACHE_FRONTEND_BYTE_W = 2;
    localparam int CACHE_FRONTEND_DATA_W = 32;
    localparam bit WORD_ADDR             = 1'b0;
    localparam int PACKET_FIELDS         = 2;
    localparam int META_W                = 16;
    localparam int ARB_NUM_REQUESTERS    = 4;

    typedef enum logic [2:0] {
        CMD_INVALID   = 3'd0,
        CMD_MEM_READ  = 3'd1,
        CMD_MEM_WRITE = 3'd2,
        CMD_ENGINE    = 3'd3,
        CMD_CONTROL   = 3'd4
    } MemoryCommand;

    typedef struct packed {
        logic [31:0] base;
        logic [31:0] offset;
        logic        direction;
        logic [4:0]  amount;
    } MemoryAddress;

    typedef struct packed {
        logic [PACKET_FIELDS-1:0][CACHE_FRONTEND_DATA_W-1:0] field;
    } MemoryData;

    typedef struct packed {
        logic         valid;
        MemoryCommand cmd;
        logic [META_W-1:0] meta;
        MemoryAddress address;
        MemoryData    data;
    } MemoryPacket;

    typedef struct packed {
        logic                               valid;
        logic [CACHE_ADDR_W-1:0]            addr;
        logic [CACHE_FRONTEND_DATA_W-1:0]   wdata;
        logic [CACHE_FRONTEND_DATA_W/8-1:0] wstrb;
    } CacheIob;

    typedef struct packed {
        CacheIob           iob;
        logic [META_W-1:0] meta;
        MemoryData         data;
    } CacheRequest;

    typedef struct packed {
        logic                             valid;
        logic [CACHE_FRONTEND_DATA_W-1:0] rdata;
        logic [META_W-1:0]                meta;
    } CacheResponse;

    typedef struct packed {
        logic empty;
        logic full;
    } FIFOStateSignalsOutput;

    typedef struct packed {
        logic rd_en;
        logic wr_en;
    } FIFOStateSignalsInput;

    typedef logic [$clog2(ARB_NUM_REQUESTERS)-1:0] CacheArbiterTag;

    // The control-field bits above the front-end address are always zero here.
    function automatic CacheRequest map_memory_packet_to_cache_request(input MemoryPacket pkt);
        CacheRequest req;
        logic [31:0] shifted;
        logic [CACHE_FRONTEND_ADDR_W-1:0] frontAddr;
        req = '0;
        shifted = pkt.address.direction ? (pkt.address.offset << pkt.address.amount)
                                        : (pkt.address.offset >> pkt.address.amount);
        frontAddr = CACHE_FRONTEND_ADDR_W'(pkt.address.base + shifted);
        if (WORD_ADDR) begin
            frontAddr = frontAddr >> CACHE_FRONTEND_BYTE_W;
        end
        req.iob.valid = pkt.valid;
        req.iob.addr  = CACHE_ADDR_W'(frontAddr);
        req.iob.wdata = pkt.data.field[0];
        req.iob.wstrb = (pkt.cmd == CMD_MEM_WRITE) ? '1 : '0;
        req.meta      = pkt.meta;
        req.data      = pkt.data;
        return req;
    endfunction

endpackage

// File: rtl/cache_request_arbiter_tag_fifo.sv
// In-order FIFO of requester indices for requests the cache has accepted;
// the head names the requester owed the next response.
module cache_arbiter_tag_fifo
    import cache_request_arbiter_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  FIFOStateSignalsInput  i_ctrl,
    input  logic [WIDTH-1:0]      i_din,
    output logic [WIDTH-1:0]      o_dout,
    output FIFOStateSignalsOutput o_state
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_write;
    logic             w_do_read;

    assign o_state.empty = (r_count == '0);
    assign o_state.full  = (r_count == (AW+1)'(DEPTH));
    assign w_do_write    = i_ctrl.wr_en && !o_state.full;
    assign w_do_read     = i_ctrl.rd_en && !o_state.empty;
    assign o_dout        = r_mem[r_rd_ptr];

    always_ff @(posedge i_clk) begin
        if (w_do_write) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_write) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_read)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_write, w_do_read})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/cache_request_arbiter.sv
// Round-robin arbiter sharing one cache front-end port among several requesters,
// routing in-order responses back through a tag FIFO.
module cache_request_arbiter
    import cache_request_arbiter_pkg::*;
#(
    parameter int NUM_REQUESTERS  = 4,
    parameter int MAX_OUTSTANDING = 16
) (
    input  logic                             ap_clk,
    input  logic                             areset,
    input  MemoryPacket                      request_in [NUM_REQUESTERS],
    output logic [NUM_REQUESTERS-1:0]        request_in_ready,
    output CacheRequest                      request_out,
    input  logic                             request_out_ready,
    input  CacheResponse                     response_in,
    output CacheResponse                     response_out [NUM_REQUESTERS],
    output logic [$clog2(MAX_OUTSTANDING):0] outstanding_count,
    output logic                             error_orphan_response,
    output logic                             idle_out
);

    localparam int TAG_W = $clog2(NUM_REQUESTERS);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    CacheRequest           r_req_out;
    logic [TAG_W-1:0]      r_out_tag;
    logic [TAG_W-1:0]      r_rr_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_orphan;
    CacheResponse          r_resp_out [NUM_REQUESTERS];

    logic                  w_found;
    logic [TAG_W-1:0]      w_winner;
    logic                  w_slot_free;
    logic                  w_room;
    logic                  w_grant;
    logic                  w_is_mem;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_orphan;
    logic [CNT_W-1:0]      w_inflight;
    logic [TAG_W-1:0]      w_fifo_head;
    FIFOStateSignalsInput  w_fifo_ctrl;
    FIFOStateSignalsOutput w_fifo_state;

    function automatic logic [TAG_W-1:0] offsetIndex(input logic [TAG_W-1:0] ptr, input int offs);
        int sum;
        sum = int'(ptr) + offs;
        if (sum >= NUM_REQUESTERS) sum = sum - NUM_REQUESTERS;
        return TAG_W'(sum);
    endfunction

    // Scanning from the far end lets the closest valid requester to rr_ptr win.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int i = NUM_REQUESTERS - 1; i >= 0; i--) begin
            if (request_in[offsetIndex(r_rr_ptr, i)].valid) begin
                w_found  = 1'b1;
                w_winner = offsetIndex(r_rr_ptr, i);
            end
        end
    end

    always_comb begin
        w_slot_free      = !r_req_out.iob.valid || request_out_ready;
        w_inflight       = r_count + CNT_W'(r_req_out.iob.valid);
        w_room           = (w_inflight < CNT_W'(MAX_OUTSTANDING)) && !w_fifo_state.full;
        w_grant          = !areset && w_slot_free && w_room && w_found;
        w_is_mem         = (request_in[w_winner].cmd == CMD_MEM_READ) ||
                           (request_in[w_winner].cmd == CMD_MEM_WRITE);
        w_push           = r_req_out.iob.valid && request_out_ready;
        w_pop            = response_in.valid && !w_fifo_state.empty;
        w_orphan         = response_in.valid && w_fifo_state.empty;
        w_fifo_ctrl      = '0;
        w_fifo_ctrl.wr_en = w_push;
        w_fifo_ctrl.rd_en = w_pop;
        request_in_ready = '0;
        if (w_grant) request_in_ready[w_winner] = 1'b1;
    end

    cache_arbiter_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (TAG_W)
    ) u_tag_fifo (
        .i_clk   (ap_clk),
        .i_reset (areset),
        .i_ctrl  (w_fifo_ctrl),
        .i_din   (r_out_tag),
        .o_dout  (w_fifo_head),
        .o_state (w_fifo_state)
    );

    // Non-memory grants fall through to the clear branch, so they are simply consumed.
    always_ff @(posedge ap_clk) begin
        if (areset) begin
            r_req_out <= '0;
            r_out_tag <= '0;
            r_rr_ptr  <= '0;
            r_count   <= '0;
            r_orphan  <= 1'b0;
            for (int i = 0; i < NUM_REQUESTERS; i++) r_resp_out[i] <= '0;
        end else begin
            if (w_grant && w_is_mem) begin
                r_req_out <= map_memory_packet_to_cache_request(request_in[w_winner]);
                r_out_tag <= w_winner;
            end else if (w_slot_free) begin
                r_req_out <= '0;
            end
            if (w_grant) r_rr_ptr <= offsetIndex(w_winner, 1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            for (int i = 0; i < NUM_REQUESTERS; i++) r_resp_out[i] <= '0;
            if (w_pop) r_resp_out[w_fifo_head] <= response_in;
            if (w_orphan) r_orphan <= 1'b1;
        end
    end

    assign request_out           = r_req_out;
    assign response_out          = r_resp_out;
    assign outstanding_count     = r_count;
    assign error_orphan_response = r_orphan;
    assign idle_out              = (r_count == '0) && !r_req_out.iob.valid;

endmodule
